// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared regfile types, widths and writeback priority states
package regfile_pkg;

  localparam int REG_AW_DEFAULT = 6;
  localparam int REG_DW_DEFAULT = 32;

  typedef logic [5:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;

  typedef enum logic {
    LD_PRI  = 1'b0,
    ALU_PRI = 1'b1
  } wb_pri_e;

  localparam reg_addr_t REG_ZERO = '0;

  function automatic int wb_cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/wb_starve_counter.sv
// rtl/wb_starve_counter.sv - saturating ALU stall counter; o_reach flags a stall landing on MAX_WAIT
module wb_starve_counter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_reach
);

  localparam int            CW   = wb_cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] CMAX = CW'(MAX_WAIT);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_clr) begin
      w_count_nxt = '0;
    end else if (i_inc && (r_count != CMAX)) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  // Asserted in the stall cycle itself so priority flips in time for the next cycle.
  assign o_reach = i_inc && !i_clr && (w_count_nxt == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - LD/ALU writeback arbiter onto the regfile write port; REGFILE_WB_BYPASS_EN adds read forwarding
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int AW       = REG_AW_DEFAULT,
  parameter int DW       = REG_DW_DEFAULT,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  output logic          we3,
  output logic [AW-1:0] addr3,
  output logic [DW-1:0] writeData3,
  output logic          starve_active
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
`endif
);

  wb_pri_e       r_state;
  wb_pri_e       w_state_nxt;
  logic          r_starve;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          w_reach;
  logic          w_grant;
  logic [AW-1:0] w_gaddr;
  logic [DW-1:0] w_gdata;
  logic          w_write;

  wb_starve_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (alu_valid && !alu_ready),
    .i_clr  (alu_ready),
    .o_reach(w_reach)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LD_PRI;
      r_starve <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= (w_state_nxt == ALU_PRI);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LD_PRI:  if (w_reach) w_state_nxt = ALU_PRI;
      ALU_PRI: if (alu_ready || !alu_valid) w_state_nxt = LD_PRI;
      default: w_state_nxt = LD_PRI;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    alu_ready = 1'b0;
    if (r_state == ALU_PRI) begin
      if (alu_valid)     alu_ready = 1'b1;
      else if (ld_valid) ld_ready  = 1'b1;
    end else begin
      if (ld_valid)       ld_ready  = 1'b1;
      else if (alu_valid) alu_ready = 1'b1;
    end
  end

  assign starve_active = r_starve;

  assign w_grant = ld_ready || alu_ready;
  assign w_gaddr = alu_ready ? alu_addr : ld_addr;
  assign w_gdata = alu_ready ? alu_data : ld_data;
  // Register-0 writes are acknowledged but never reach the port, keeping $0 hard-wired.
  assign w_write = w_grant && (w_gaddr != AW'(REG_ZERO));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr <= w_gaddr;
        r_data <= w_gdata;
      end
    end
  end

  assign we3        = r_we;
  assign addr3      = r_addr;
  assign writeData3 = r_data;

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_hit1  = r_we && (r_addr == rd_addr1) && (rd_addr1 != AW'(REG_ZERO));
  assign fwd_hit2  = r_we && (r_addr == rd_addr2) && (rd_addr2 != AW'(REG_ZERO));
  assign fwd_data1 = fwd_hit1 ? r_data : '0;
  assign fwd_data2 = fwd_hit2 ? r_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int AW       = 6;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;
  localparam int NRAND    = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          we3;
  logic [AW-1:0] addr3;
  logic [DW-1:0] writeData3;
  logic          starve_active;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data1;
  logic [DW-1:0] fwd_data2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .we3          (we3),
    .addr3        (addr3),
    .writeData3   (writeData3),
    .starve_active(starve_active)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  // Regfile stand-in that captures whatever the arbiter presents on the write port.
  logic [DW-1:0] rf [64];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) rf[i] <= '0;
    end else if (we3) begin
      rf[addr3] <= writeData3;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          lv;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          e_lr;
    logic          e_ar;
    logic          e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_st;
  } vec_t;

  vec_t tbl [17];

  // Reference model state: pending write-port contents and ALU starvation bookkeeping.
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_stalls;
  logic          m_forced;
  logic          g_ld, g_alu, g_ld_prev, g_alu_prev;
  logic [AW-1:0] ga;

  initial begin
    tbl[0]  = '{0, 0,  0,            0, 0, 0,            0, 0, 0, 0,  0,            0};
    tbl[1]  = '{1, 1,  32'h0000FFFF, 0, 0, 0,            1, 0, 0, 0,  0,            0};
    tbl[2]  = '{0, 0,  0,            0, 0, 0,            0, 0, 1, 1,  32'h0000FFFF, 0};
    tbl[3]  = '{0, 0,  0,            0, 0, 0,            0, 0, 0, 1,  32'h0000FFFF, 0};
    tbl[4]  = '{1, 2,  32'h11111111, 1, 3, 32'h22222222, 1, 0, 0, 1,  32'h0000FFFF, 0};
    tbl[5]  = '{0, 0,  0,            1, 3, 32'h22222222, 0, 1, 1, 2,  32'h11111111, 0};
    tbl[6]  = '{0, 0,  0,            0, 0, 0,            0, 0, 1, 3,  32'h22222222, 0};
    tbl[7]  = '{0, 0,  0,            1, 0, 32'hDEADBEEF, 0, 1, 0, 3,  32'h22222222, 0};
    tbl[8]  = '{0, 0,  0,            0, 0, 0,            0, 0, 0, 3,  32'h22222222, 0};
    tbl[9]  = '{1, 10, 32'd10,       1, 4, 32'hAAAA0004, 1, 0, 0, 3,  32'h22222222, 0};
    tbl[10] = '{1, 11, 32'd11,       1, 4, 32'hAAAA0004, 1, 0, 1, 10, 32'd10,       0};
    tbl[11] = '{1, 12, 32'd12,       1, 4, 32'hAAAA0004, 1, 0, 1, 11, 32'd11,       0};
    tbl[12] = '{1, 13, 32'd13,       1, 4, 32'hAAAA0004, 1, 0, 1, 12, 32'd12,       0};
    tbl[13] = '{1, 14, 32'd14,       1, 4, 32'hAAAA0004, 0, 1, 1, 13, 32'd13,       1};
    tbl[14] = '{1, 14, 32'd14,       0, 0, 0,            1, 0, 1, 4,  32'hAAAA0004, 0};
    tbl[15] = '{0, 0,  0,            0, 0, 0,            0, 0, 1, 14, 32'd14,       0};
    tbl[16] = '{0, 0,  0,            0, 0, 0,            0, 0, 0, 14, 32'd14,       0};

    rst_n = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
`ifdef REGFILE_WB_BYPASS_EN
    rd_addr1 = '0; rd_addr2 = '0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset arriving mid-cycle must kill an already-registered write.
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 6'd7; ld_data = 32'h77;
    #2 chk("midrst_ld_ready", ld_ready, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    #2 chk("midrst_we_before", we3, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we3", we3, 0);
    chk("midrst_addr3", addr3, 0);
    chk("midrst_wdata3", writeData3, 0);
    chk("midrst_starve", starve_active, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      ld_valid = tbl[i].lv;  ld_addr = tbl[i].la;  ld_data = tbl[i].ld;
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      #2;
      chk($sformatf("row%0d_ld_ready", i), ld_ready, tbl[i].e_lr);
      chk($sformatf("row%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("row%0d_we3", i), we3, tbl[i].e_we);
      chk($sformatf("row%0d_addr3", i), addr3, tbl[i].e_a);
      chk($sformatf("row%0d_wdata3", i), writeData3, tbl[i].e_d);
      chk($sformatf("row%0d_starve", i), starve_active, tbl[i].e_st);
      @(negedge clk);
    end
    chk("rf_r0", rf[0], 0);
    chk("rf_r1", rf[1], 32'h0000FFFF);
    chk("rf_r2", rf[2], 32'h11111111);
    chk("rf_r3", rf[3], 32'h22222222);
    chk("rf_r4", rf[4], 32'hAAAA0004);

    // Randomised traffic against the rule-level model.
    ld_valid = 1'b0; alu_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_we = 1'b0; m_addr = '0; m_data = '0; m_stalls = 0; m_forced = 1'b0;
    g_ld_prev = 1'b0; g_alu_prev = 1'b0;
    for (int c = 0; c < NRAND; c++) begin
      if (!ld_valid || g_ld_prev) begin
        ld_valid = ($urandom_range(0, 9) < 8);
        ld_addr  = AW'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      if (!alu_valid || g_alu_prev) begin
        alu_valid = ($urandom_range(0, 9) < 5);
        alu_addr  = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      #2;
      g_alu = alu_valid && (m_forced || !ld_valid);
      g_ld  = ld_valid && !g_alu;
      chk("rnd_ld_ready", ld_ready, g_ld);
      chk("rnd_alu_ready", alu_ready, g_alu);
      chk("rnd_we3", we3, m_we);
      chk("rnd_addr3", addr3, m_addr);
      chk("rnd_wdata3", writeData3, m_data);
      chk("rnd_starve", starve_active, m_forced);

      if (g_alu) m_stalls = 0;
      else if (alu_valid) m_stalls++;
      m_forced = alu_valid && !g_alu && (m_stalls >= MAX_WAIT);
      m_we = 1'b0;
      if (g_ld || g_alu) begin
        ga = g_alu ? alu_addr : ld_addr;
        if (ga != 0) begin
          m_we   = 1'b1;
          m_addr = ga;
          m_data = g_alu ? alu_data : ld_data;
        end
      end
      g_ld_prev = g_ld; g_alu_prev = g_alu;
      @(negedge clk);
    end

`ifdef REGFILE_WB_BYPASS_EN
    ld_valid = 1'b0; alu_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_addr1 = 6'd5; rd_addr2 = 6'd0;
    alu_valid = 1'b1; alu_addr = 6'd5; alu_data = 32'hCAFEF00D;
    #2 chk("byp_alu_ready", alu_ready, 1);
    chk("byp_hit1_early", fwd_hit1, 0);
    @(negedge clk);
    alu_valid = 1'b0;
    #2;
    chk("byp_hit1", fwd_hit1, 1);
    chk("byp_data1", fwd_data1, 32'hCAFEF00D);
    chk("byp_hit2", fwd_hit2, 0);
    chk("byp_data2", fwd_data2, 0);
    rd_addr2 = 6'd5;
    #1;
    chk("byp_hit2_same", fwd_hit2, 1);
    chk("byp_data2_same", fwd_data2, 32'hCAFEF00D);
    @(negedge clk);
    #2 chk("byp_hit1_after", fwd_hit1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
